// File: rtl/fsm_oe16s_pkg.sv
// Shared types and helpers for the 16-state one-hot sequencer and its dwell timer.
package fsm_oe16s_pkg;

  localparam int NSTATES = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    WAIT  = 2'd2
  } phase_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } onehot_dec_t;

  // valid only when exactly one bit is hot; idx is the highest hot bit otherwise
  function automatic onehot_dec_t onehot16_to_idx(input logic [15:0] vec);
    onehot_dec_t r;
    logic [4:0]  n;
    r.valid = 1'b0;
    r.idx   = 4'd0;
    n       = 5'd0;
    for (int i = 0; i < NSTATES; i++) begin
      if (vec[i]) begin
        n     = n + 5'd1;
        r.idx = 4'(i);
      end
    end
    r.valid = (n == 5'd1);
    return r;
  endfunction

endpackage

// File: rtl/fsm_oe16s_dwell_timer_if.sv
// Sequencer-side bundle of the dwell timer: enable, per-state dwell, state vector, strobes, status.
interface fsm_oe16s_dwell_timer_if #(
  parameter int DW = 8,
  parameter int LW = 16
) ();

  logic            en;
  logic [16*DW-1:0] dwell_cfg;

  logic st0, st1, st2, st3, st4, st5, st6, st7;
  logic st8, st9, sta, stb, stc, std, ste, stf;

  logic t01, t12, t23, t34, t45, t56, t67, t78;
  logic t89, t9a, tab, tbc, tcd, tde, tef, tf0;

  logic          lap;
  logic [LW-1:0] lap_cnt;
  logic          err;

  modport slave (
    input  en, dwell_cfg,
    input  st0, st1, st2, st3, st4, st5, st6, st7,
    input  st8, st9, sta, stb, stc, std, ste, stf,
    output t01, t12, t23, t34, t45, t56, t67, t78,
    output t89, t9a, tab, tbc, tcd, tde, tef, tf0,
    output lap, lap_cnt, err
  );

  modport master (
    output en, dwell_cfg,
    output st0, st1, st2, st3, st4, st5, st6, st7,
    output st8, st9, sta, stb, stc, std, ste, stf,
    input  t01, t12, t23, t34, t45, t56, t67, t78,
    input  t89, t9a, tab, tbc, tcd, tde, tef, tf0,
    input  lap, lap_cnt, err
  );

endinterface

// File: rtl/onehot16_enc.sv
// 16-bit one-hot to index encoder with an exactly-one-hot valid flag; purely combinational.
module onehot16_enc
  import fsm_oe16s_pkg::*;
(
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        valid
);

  onehot_dec_t dec;

  always_comb begin
    dec   = onehot16_to_idx(vec);
    idx   = dec.idx;
    valid = dec.valid;
  end

endmodule

// File: rtl/fsm_oe16s_dwell_timer.sv
// Per-state dwell timer that turns the one-hot sequencer into a self-timed 16-phase cycle.
//   state | meaning
//   IDLE  | no valid state latched; load on the next one-hot vector
//   COUNT | counting down the dwell of state idx; strobe at cnt == 0 with en
//   WAIT  | strobe issued; hold until the sequencer shows a different state
module fsm_oe16s_dwell_timer
  import fsm_oe16s_pkg::*;
#(
  parameter int DW = 8,
  parameter int LW = 16
) (
  input logic                    clk,
  input logic                    rst,
  fsm_oe16s_dwell_timer_if.slave bus
);

  localparam logic [NSTATES-1:0] STROBE_ONE = 16'h0001;

  logic [NSTATES-1:0] st_vec;
  logic [3:0]         st_idx;
  logic               st_valid;

  phase_t             phase_q, phase_d;
  logic [DW-1:0]      cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic               fire;
  logic [NSTATES-1:0] strobe;

  logic [LW-1:0]      lap_cnt_q;
  logic               lap_q;
  logic               err_q;

  logic [DW-1:0]      dwell_arr [NSTATES];
  logic [DW-1:0]      dwell_sel;

  assign st_vec = {bus.stf, bus.ste, bus.std, bus.stc, bus.stb, bus.sta, bus.st9, bus.st8,
                   bus.st7, bus.st6, bus.st5, bus.st4, bus.st3, bus.st2, bus.st1, bus.st0};

  onehot16_enc u_enc (
    .vec   (st_vec),
    .idx   (st_idx),
    .valid (st_valid)
  );

  for (genvar k = 0; k < NSTATES; k++) begin : g_cfg
    assign dwell_arr[k] = bus.dwell_cfg[k*DW +: DW];
  end

  assign dwell_sel = dwell_arr[st_idx];

  // An illegal vector or a state other than idx always wins over the count,
  // so no strobe can leak out in the cycle the sequencer misbehaves.
  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fire    = 1'b0;
    if (!st_valid) begin
      phase_d = IDLE;
    end else if (phase_q == IDLE || st_idx != idx_q) begin
      phase_d = COUNT;
      cnt_d   = dwell_sel;
      idx_d   = st_idx;
    end else if (phase_q == COUNT && bus.en) begin
      if (cnt_q == '0) begin
        fire    = 1'b1;
        phase_d = WAIT;
      end else begin
        cnt_d = cnt_q - DW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  assign strobe = (fire && rst) ? (STROBE_ONE << idx_q) : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lap_q     <= 1'b0;
      err_q     <= 1'b0;
      lap_cnt_q <= '0;
    end else begin
      lap_q <= strobe[NSTATES-1];
      err_q <= ~st_valid;
      if (strobe[NSTATES-1]) begin
        lap_cnt_q <= lap_cnt_q + LW'(1);
      end
    end
  end

  assign bus.t01 = strobe[0];
  assign bus.t12 = strobe[1];
  assign bus.t23 = strobe[2];
  assign bus.t34 = strobe[3];
  assign bus.t45 = strobe[4];
  assign bus.t56 = strobe[5];
  assign bus.t67 = strobe[6];
  assign bus.t78 = strobe[7];
  assign bus.t89 = strobe[8];
  assign bus.t9a = strobe[9];
  assign bus.tab = strobe[10];
  assign bus.tbc = strobe[11];
  assign bus.tcd = strobe[12];
  assign bus.tde = strobe[13];
  assign bus.tef = strobe[14];
  assign bus.tf0 = strobe[15];

  assign bus.lap     = lap_q;
  assign bus.lap_cnt = lap_cnt_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_fsm_oe16s_dwell_timer.sv
// Bench for the dwell timer: a behavioural one-hot sequencer closes the loop around the DUT.
module tb_fsm_oe16s_dwell_timer;

  typedef struct {
    logic [7:0]  d;
    int          len;
    logic [15:0] tv;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [15:0] seq;
  logic        force_en;
  logic [15:0] force_val;
  logic        jump_req;
  logic [15:0] jump_val;
  logic [15:0] st_drv;
  logic [15:0] tvec;

  int errors;
  int checks;
  int multi_hot;
  int lap_pulses;

  vec_t tbl [80];
  int   exp_lapc [5];

  fsm_oe16s_dwell_timer_if #(.DW(8), .LW(2)) bus ();

  fsm_oe16s_dwell_timer #(.DW(8), .LW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sequencer: advances one state per strobe, resets to S0
  always @(posedge clk) begin
    if (!rst) seq <= 16'h0001;
    else if (jump_req) seq <= jump_val;
    else if (tvec != 16'h0000) seq <= {seq[14:0], seq[15]};
  end

  assign st_drv = force_en ? force_val : seq;
  assign bus.st0 = st_drv[0];
  assign bus.st1 = st_drv[1];
  assign bus.st2 = st_drv[2];
  assign bus.st3 = st_drv[3];
  assign bus.st4 = st_drv[4];
  assign bus.st5 = st_drv[5];
  assign bus.st6 = st_drv[6];
  assign bus.st7 = st_drv[7];
  assign bus.st8 = st_drv[8];
  assign bus.st9 = st_drv[9];
  assign bus.sta = st_drv[10];
  assign bus.stb = st_drv[11];
  assign bus.stc = st_drv[12];
  assign bus.std = st_drv[13];
  assign bus.ste = st_drv[14];
  assign bus.stf = st_drv[15];

  assign tvec = {bus.tf0, bus.tef, bus.tde, bus.tcd, bus.tbc, bus.tab, bus.t9a, bus.t89,
                 bus.t78, bus.t67, bus.t56, bus.t45, bus.t34, bus.t23, bus.t12, bus.t01};

  always @(negedge clk) begin
    #2;
    if ($countones(tvec) > 1) multi_hot++;
    if (bus.lap) lap_pulses++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_all(input logic [7:0] d);
    for (int k = 0; k < 16; k++) bus.dwell_cfg[k*8 +: 8] = d;
  endtask

  task automatic set_from_tbl(input int base);
    for (int k = 0; k < 16; k++) bus.dwell_cfg[k*8 +: 8] = tbl[base+k].d;
  endtask

  // Called at the negedge of a state's entry cycle numbered start_c; returns the
  // cycle number (entry = 1) in which a strobe appears. en is low for cycles off_from..off_to.
  task automatic measure(input int start_c, input int off_from, input int off_to,
                         output int len, output logic [15:0] tv);
    int c;
    c   = start_c;
    len = -1;
    tv  = '0;
    while (c < 400) begin
      bus.en = !(c >= off_from && c <= off_to);
      #1;
      if (tvec != 16'h0000) begin
        len = c;
        tv  = tvec;
        break;
      end
      @(negedge clk);
      c++;
    end
    bus.en = 1'b1;
  endtask

  initial begin
    int          len;
    logic [15:0] tv;
    logic [15:0] one16;
    logic [7:0]  dm [16];
    int          lm [16];

    errors     = 0;
    checks     = 0;
    multi_hot  = 0;
    lap_pulses = 0;
    one16      = 16'h0001;
    dm = '{8'd0, 8'd255, 8'd5, 8'd1, 8'd2, 8'd7, 8'd3, 8'd0,
           8'd9, 8'd4, 8'd6, 8'd1, 8'd8, 8'd2, 8'd10, 8'd3};
    lm = '{2, 257, 7, 3, 4, 9, 5, 2, 11, 6, 8, 3, 10, 4, 12, 5};
    exp_lapc = '{1, 2, 3, 0, 1};

    // lap 1 all D=3, lap 2 mixed incl. zero/max, laps 3..5 all D=0
    for (int k = 0; k < 16; k++) begin
      tbl[k]    = '{d: 8'd3,  len: 5,     tv: one16 << k};
      tbl[16+k] = '{d: dm[k], len: lm[k], tv: one16 << k};
      tbl[32+k] = '{d: 8'd0,  len: 2,     tv: one16 << k};
      tbl[48+k] = '{d: 8'd0,  len: 2,     tv: one16 << k};
      tbl[64+k] = '{d: 8'd0,  len: 2,     tv: one16 << k};
    end

    rst       = 1'b0;
    bus.en    = 1'b1;
    force_en  = 1'b0;
    force_val = 16'h0000;
    jump_req  = 1'b0;
    jump_val  = 16'h0000;
    set_from_tbl(0);

    repeat (3) @(negedge clk);
    chk("reset_strobes", tvec, 0);
    chk("reset_lap", bus.lap, 0);
    chk("reset_lap_cnt", bus.lap_cnt, 0);
    chk("reset_err", bus.err, 0);

    rst = 1'b1;
    for (int i = 0; i < 80; i++) begin
      measure(1, 0, -1, len, tv);
      chk("dwell_len", len, tbl[i].len);
      chk("strobe_sel", tv, tbl[i].tv);
      if (i % 16 == 15) begin
        if (i < 79) set_from_tbl(i + 1);
        else begin
          set_all(8'd3);
          bus.dwell_cfg[0*8 +: 8] = 8'd4;
          bus.dwell_cfg[2*8 +: 8] = 8'd5;
          bus.dwell_cfg[5*8 +: 8] = 8'd9;
        end
      end
      @(negedge clk);
      if (i % 16 == 15) begin
        chk("lap_pulse", bus.lap, 1);
        chk("lap_cnt", bus.lap_cnt, exp_lapc[i/16]);
      end
    end

    // S0 D=4, S1 D=3
    measure(1, 0, -1, len, tv);
    chk("s0_len", len, 6);
    chk("s0_strobe", tv, 16'h0001);
    @(negedge clk);
    measure(1, 0, -1, len, tv);
    chk("s1_len", len, 5);
    @(negedge clk);

    // S2 D=5 with en low for cycles 3..6
    measure(1, 3, 6, len, tv);
    chk("en_gap_len", len, 11);
    chk("en_gap_strobe", tv, 16'h0004);
    @(negedge clk);

    // S3 D=3 with en low exactly at cnt==0 (cycle 5) and one more
    measure(1, 5, 6, len, tv);
    chk("en_at_zero_len", len, 7);
    chk("en_at_zero_strobe", tv, 16'h0008);
    @(negedge clk);

    // S4 D=3: illegal vector in the cycle the strobe would fire
    repeat (4) @(negedge clk);
    force_val = 16'h0003;
    force_en  = 1'b1;
    #1;
    chk("illegal_no_strobe", tvec, 0);
    @(negedge clk);
    force_en = 1'b0;
    #1;
    chk("illegal_err", bus.err, 1);
    chk("illegal_idle_no_strobe", tvec, 0);
    @(negedge clk);
    #1;
    chk("err_clears", bus.err, 0);
    measure(2, 0, -1, len, tv);
    chk("reload_len", len, 5);
    chk("reload_strobe", tv, 16'h0010);
    @(negedge clk);

    // S5 D=9: jump to S0 while cnt == 7
    repeat (2) @(negedge clk);
    jump_val = 16'h0001;
    jump_req = 1'b1;
    @(negedge clk);
    jump_req = 1'b0;
    #1;
    chk("jump_no_strobe", tvec, 0);
    measure(1, 0, -1, len, tv);
    chk("jump_len", len, 6);
    chk("jump_strobe", tv, 16'h0001);
    @(negedge clk);
    chk("jump_lap", bus.lap, 0);
    chk("jump_lap_cnt", bus.lap_cnt, 1);

    // reset in the middle of S1's count
    set_all(8'd3);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_strobes_during", tvec, 0);
    @(negedge clk);
    chk("midrst_strobes", tvec, 0);
    chk("midrst_lap", bus.lap, 0);
    chk("midrst_lap_cnt", bus.lap_cnt, 0);
    chk("midrst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b1;
    measure(1, 0, -1, len, tv);
    chk("restart_len", len, 5);
    chk("restart_strobe", tv, 16'h0001);
    @(negedge clk);
    measure(1, 0, -1, len, tv);
    chk("restart_s1_len", len, 5);
    chk("restart_s1_strobe", tv, 16'h0002);

    @(negedge clk);
    #3;
    chk("strobe_exclusive", multi_hot, 0);
    chk("lap_pulse_total", lap_pulses, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fsm_oe16s_dwell_timer.md
# fsm_oe16s_dwell_timer

Programmable per-state dwell timer that drives the 16-state one-hot sequencer. It consumes the sequencer's one-hot state outputs `st0`..`stf` and produces the transition strobes `t01`..`tf0`. Each state is held for a programmed number of cycles before the matching strobe fires, which makes the sequencer a self-timed 16-phase cycle. It also counts completed laps and flags illegal (non-one-hot) state vectors.

## Interface
Parameters:
- `DW`, 8: dwell counter width per state.
- `LW`, 16: lap counter width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `en`  in  1  count enable; when low, the counter freezes and no strobe fires.
- `dwell_cfg`  in  16*DW  dwell value per state; state k uses bits [k*DW +: DW].
- `st0`..`stf`  in  1 each  one-hot state vector from the sequencer.
- `t01`..`tf0`  out  1 each  transition strobes, combinational from registered phase/count/index and `en`.
- `lap`  out  1  one-cycle pulse, registered, on the cycle after `tf0` fires.
- `lap_cnt`  out  LW  completed laps, wraps modulo 2^LW.
- `err`  out  1  registered; high for one cycle after an illegal state vector is sampled.

## Operation
Phases: IDLE, COUNT, WAIT.

- **IDLE**
  - If the state vector is one-hot with index k: load `cnt = dwell_cfg[k]`, latch `idx = k`, go to COUNT.
  - Otherwise stay in IDLE.
- **COUNT**
  - Strobe `t<k><k+1 mod 16>` is high iff `en` is high and `cnt == 0`. Go to WAIT on that edge.
  - Else if `en` is high: `cnt` decrements by 1.
  - If `en` is low: hold.
- **WAIT**
  - All strobes stay low.
  - When a one-hot vector with index ≠ `idx` is sampled: load the new index and its dwell, go to COUNT.
- **Any phase, one-hot index ≠ `idx`** (forced change, e.g. sequencer reset): reload from the new index and go to COUNT. This takes priority over the normal transition.
- **Any phase, illegal vector** (zero or ≥2 bits hot): go to IDLE, set `err` next cycle, no strobe that cycle.
- **Dwell snapshot:** `dwell_cfg` is sampled only at load. Later changes take effect at the next state entry.
- **Lap counting:** `lap_cnt` increments by 1 on each edge where `tf0` is high, wrapping from 2^LW−1 to 0.
- **Strobe exclusivity:** at most one strobe is high in any cycle.

## Timing
- **Reset** (`rst` = 0 at an edge): phase = IDLE, `cnt` = 0, `idx` = 0, `lap_cnt` = 0, `lap` = 0, `err` = 0. All `t*` are 0 during and after reset until COUNT.
- **Dwell length:** with `en` held high and dwell D, the sequencer holds a state for exactly D+2 cycles: entry cycle, D count cycles, strobe cycle. D = 0 gives 2 cycles.
- **`en` low:** each `en`-low cycle during COUNT adds one cycle of dwell. If `en` drops in the cycle where `cnt == 0`, the strobe is suppressed and fires in the first later cycle with `en` high.
- **Sequencer response:** the sequencer registers the strobe on the same edge the timer enters WAIT. The new state is visible the next cycle, and the timer reloads at the end of that cycle.
- **Latency from reset release to first `t01`:** D0+2 cycles (IDLE sample, then D0 counts, then strobe).
- **`err`:** asserts one cycle after the illegal vector and clears the following cycle unless the vector is still illegal.

## Structure
- **Package `fsm_oe16s_pkg`:**
  - `NSTATES` = 16.
  - Phase enum `{IDLE, COUNT, WAIT}`, 2-bit.
  - Function `onehot16_to_idx` returning a 4-bit index plus a valid flag.
- **Sub-module `onehot16_enc`:** 16-bit one-hot to 4-bit index, plus `valid` (exactly one bit hot). Purely combinational and reused by other monitors.
- **Top level:** phase register, `cnt`, `idx`, lap counter, `err`/`lap` registers, strobe decode (16 outputs from `idx` with `cnt == 0` gating).

## Test plan
- **Reset release:** `dwell_cfg` all 3, `en` = 1, sequencer connected → `t01` high 5 cycles after reset release. Each state lasts 5 cycles. `tf0` on cycle 80 of the lap, `lap_cnt` = 1, `lap` pulses once.
- **Zero/max dwell:** D0 = 0, D1 = 255 → S0 lasts 2 cycles, S1 lasts 257 cycles. No double strobe in WAIT.
- **Enable gating:** `en` dropped for 4 cycles mid-count in S2 with D2 = 5 → S2 lasts 11 cycles. `en` low exactly at `cnt == 0` → strobe delayed until `en` rises.
- **Illegal vector:** force st vector to 0x0003 for one cycle → no strobes, `err` = 1 next cycle, phase IDLE. Restore 0x0004 → reload D2, count resumes.
- **Forced change in COUNT:** vector jumps S5→S0 with `cnt` = 7 → reload D0 next edge, strobe `t01` after D0 more cycles. `lap_cnt` unchanged.
- **Lap wrap and mid-operation reset:** `LW` = 2, four laps → `lap_cnt` 3→0. Assert `rst` mid-COUNT → all outputs 0 next cycle, and restart timing matches the reset-release case.
